// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract sequencer: one 16-bit carry-select adder is reused
// over WORDS cycles, LSB slice first, with the carry held in a register between slices.

module sixteenbit_carrysel (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        c_i,
  output logic [15:0] sum_o,
  output logic        c_o
);

  logic [8:0] lowSum;
  logic [8:0] highSum0;
  logic [8:0] highSum1;
  logic [8:0] highSel;

  // Upper byte is precomputed for both possible low-byte carries, then selected.
  always_comb begin
    lowSum   = {1'b0, x_i[7:0]} + {1'b0, y_i[7:0]} + {8'd0, c_i};
    highSum0 = {1'b0, x_i[15:8]} + {1'b0, y_i[15:8]};
    highSum1 = highSum0 + 9'd1;
    highSel  = lowSum[8] ? highSum1 : highSum0;
    sum_o    = {highSel[7:0], lowSum[7:0]};
    c_o      = highSel[8];
  end

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                InValid,
  output logic                InReady,
  input  logic [16*WORDS-1:0] A,
  input  logic [16*WORDS-1:0] B,
  input  logic                Cin,
  input  logic                Sub,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [16*WORDS-1:0] Result,
  output logic                Cout,
  output logic                Ovf,
  output logic                Zero
);

  localparam int W  = 16 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          outValid_q, outValid_d;

  logic [15:0]   xSlice;
  logic [15:0]   ySlice;
  logic [15:0]   adderSum;
  logic          adderCout;
  logic [W-1:0]  resultNext;

  sixteenbit_carrysel adder (
    .x_i   (xSlice),
    .y_i   (ySlice),
    .c_i   (carry_q),
    .sum_o (adderSum),
    .c_o   (adderCout)
  );

  // Slice mux for the adder inputs and slice merge for the result register.
  always_comb begin
    xSlice     = '0;
    ySlice     = '0;
    resultNext = result_q;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt_q == CW'(i)) begin
        xSlice                 = a_q[i*16 +: 16];
        ySlice                 = b_q[i*16 +: 16] ^ {16{sub_q}};
        resultNext[i*16 +: 16] = adderSum;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    outValid_d = outValid_q;

    case (state_q)
      IDLE: begin
        if (InValid) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          carry_d = Sub ? ~Cin : Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = resultNext;
        carry_d  = adderCout;
        cnt_d    = cnt_q + CW'(1);
        // Subtraction reports borrow, which is the inverse of the final carry.
        if (cnt_q == LAST) begin
          state_d    = DONE;
          cout_d     = sub_q ? ~adderCout : adderCout;
          ovf_d      = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (adderSum[15] != a_q[W-1]);
          zero_d     = (resultNext == '0);
          outValid_d = 1'b1;
        end
      end
      DONE: begin
        if (OutReady) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        outValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      outValid_q <= outValid_d;
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = outValid_q;
  assign Result   = result_q;
  assign Cout     = cout_q;
  assign Ovf      = ovf_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed-vector bench for wide_add_sequencer with WORDS=4 (64-bit operands);
// expected results are hand-computed constants.

module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         Clk;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         Cout;
  logic         Ovf;
  logic         Zero;

  int errCount;
  int checkCount;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Sub      (Sub),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Cout     (Cout),
    .Ovf      (Ovf),
    .Zero     (Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents one operand pair and returns once the acceptance edge has passed.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    int waitCycles;
    waitCycles = 0;
    while (!InReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!InReady) checkOutput("inReadyWait", 64'(InReady), 64'd1);
    A       = a;
    B       = b;
    Cin     = cin;
    Sub     = sub;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!OutValid && k < 20);
    checkOutput({tag, ".latency"}, 64'(k), 64'(WORDS));
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] expR,
                             input logic expC, input logic expO, input logic expZ);
    checkOutput({tag, ".valid"}, 64'(OutValid), 64'd1);
    checkOutput({tag, ".result"}, Result, expR);
    checkOutput({tag, ".cout"}, 64'(Cout), 64'(expC));
    checkOutput({tag, ".ovf"}, 64'(Ovf), 64'(expO));
    checkOutput({tag, ".zero"}, 64'(Zero), 64'(expZ));
  endtask

  task automatic popResult(input string tag);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checkOutput({tag, ".validDrop"}, 64'(OutValid), 64'd0);
    checkOutput({tag, ".readyBack"}, 64'(InReady), 64'd1);
  endtask

  task automatic runTxn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [W-1:0] expR,
                        input logic expC, input logic expO, input logic expZ);
    applyStimulus(a, b, cin, sub);
    waitDone(tag);
    checkResult(tag, expR, expC, expO, expZ);
    popResult(tag);
  endtask

  initial begin
    int validSeen;
    errCount   = 0;
    checkCount = 0;
    Reset      = 1'b1;
    InValid    = 1'b1;
    A          = 64'h1234_5678_9ABC_DEF0;
    B          = 64'h1111_1111_1111_1111;
    Cin        = 1'b1;
    Sub        = 1'b0;
    OutReady   = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    checkOutput("reset.outValid", 64'(OutValid), 64'd0);
    checkOutput("reset.result", Result, 64'd0);
    checkOutput("reset.flags", {61'd0, Cout, Ovf, Zero}, 64'd0);
    Reset   = 1'b0;
    InValid = 1'b0;
    tick();
    checkOutput("reset.inReady", 64'(InReady), 64'd1);
    checkOutput("reset.noCapture", 64'(OutValid), 64'd0);

    runTxn("carryIntoSlice1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    runTxn("rippleAll", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0, 1'b1);
    runTxn("subOverflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
           64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    runTxn("subWrap", 64'h0, 64'h1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    runTxn("addOverflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b1, 1'b1);

    // Result held while the consumer stalls; new operands must be ignored.
    applyStimulus(64'h1, 64'h2, 1'b0, 1'b0);
    waitDone("stall");
    for (int i = 0; i < 5; i++) begin
      A       = 64'h5555_5555_5555_5555;
      B       = 64'h5555_5555_5555_5555;
      InValid = 1'b1;
      tick();
      checkOutput("stall.inReady", 64'(InReady), 64'd0);
      checkOutput("stall.result", Result, 64'd3);
    end
    InValid = 1'b0;
    checkResult("stall", 64'd3, 1'b0, 1'b0, 1'b0);
    popResult("stall");
    runTxn("subBorrowIn", 64'h10, 64'h3, 1'b1, 1'b1, 64'hC, 1'b0, 1'b0, 1'b0);

    // Reset during the second RUN cycle aborts the transaction.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("abort.inReady", 64'(InReady), 64'd1);
    checkOutput("abort.result", Result, 64'd0);
    validSeen = 0;
    for (int i = 0; i < WORDS + 2; i++) begin
      tick();
      if (OutValid) validSeen++;
    end
    checkOutput("abort.noValid", 64'(validSeen), 64'd0);
    runTxn("afterAbort", 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
